// File: rtl/hamming_7_4_scrub_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_pkg
//  Purpose  : Shared constants, FSM state type and syndrome decode helper for
//             the Hamming (7,4) scrubber and its correction datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

   // Codeword layout is {d3,d2,d1,d0,p2,p1,p0} on bits [6:0]
   localparam int c_CW_W  = 7;
   localparam int c_SYN_W = 3;

   // Syndrome value that points at each codeword bit
   localparam logic [c_SYN_W-1:0] c_SYN_B6 = 3'd7;
   localparam logic [c_SYN_W-1:0] c_SYN_B5 = 3'd6;
   localparam logic [c_SYN_W-1:0] c_SYN_B4 = 3'd5;
   localparam logic [c_SYN_W-1:0] c_SYN_B3 = 3'd3;
   localparam logic [c_SYN_W-1:0] c_SYN_B2 = 3'd4;
   localparam logic [c_SYN_W-1:0] c_SYN_B1 = 3'd2;
   localparam logic [c_SYN_W-1:0] c_SYN_B0 = 3'd1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WAIT = 3'd2,
      ST_CHK  = 3'd3,
      ST_WR   = 3'd4,
      ST_NEXT = 3'd5,
      ST_DONE = 3'd6
   } state_e;

   // One-hot flip mask for the bit a syndrome points at; zero syndrome flips nothing
   function automatic logic [c_CW_W-1:0] syn_to_mask(input logic [c_SYN_W-1:0] syn);
      logic [c_CW_W-1:0] mask;
      mask = '0;
      case (syn)
         c_SYN_B6: mask = 7'b100_0000;
         c_SYN_B5: mask = 7'b010_0000;
         c_SYN_B4: mask = 7'b001_0000;
         c_SYN_B3: mask = 7'b000_1000;
         c_SYN_B2: mask = 7'b000_0100;
         c_SYN_B1: mask = 7'b000_0010;
         c_SYN_B0: mask = 7'b000_0001;
         default:  mask = '0;
      endcase
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_7_4_scrub_ctrl_syndrome_fix.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_7_4_syndrome_fix
//  Purpose  : Combinational Hamming (7,4) checker: syndrome, single-bit
//             corrected codeword and error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module hamming_7_4_syndrome_fix
   import hamming_pkg::*;
(
   input  logic [c_CW_W-1:0]  cw_i,
   output logic [c_SYN_W-1:0] syn_o,
   output logic [c_CW_W-1:0]  fixed_o,
   output logic               err_o
);

   logic [c_SYN_W-1:0] w_syn;

   // Parity checks over the three overlapping groups, then flip the indicated bit
   always_comb begin
      w_syn[2] = cw_i[6] ^ cw_i[5] ^ cw_i[4] ^ cw_i[2];
      w_syn[1] = cw_i[6] ^ cw_i[5] ^ cw_i[3] ^ cw_i[1];
      w_syn[0] = cw_i[6] ^ cw_i[4] ^ cw_i[3] ^ cw_i[0];
      syn_o    = w_syn;
      fixed_o  = cw_i ^ syn_to_mask(w_syn);
      err_o    = |w_syn;
   end

endmodule
`default_nettype wire

// File: rtl/hamming_7_4_scrub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_7_4_scrub_ctrl
//  Purpose  : Memory scrubber. Walks addresses 0..DEPTH-1, reads each 7-bit
//             codeword, writes back single-bit corrections and logs them.
//             Shares the RAM port with a host via a host-priority arbiter
//             with an anti-starvation limit.
//  Revision : 1.0 - initial release
// ============================================================================
module hamming_7_4_scrub_ctrl
   import hamming_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int DEPTH        = 256,
   parameter int STARVE_LIMIT = 8,
   parameter int CNT_W        = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              host_req,
   output logic              host_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [6:0]        mem_rdata,
   output logic              mem_wr_en,
   output logic [6:0]        mem_wdata,
   output logic [CNT_W-1:0]  err_count,
   output logic [ADDR_W-1:0] last_err_addr
);

   // Starve counter must be able to hold STARVE_LIMIT itself
   localparam int                c_STV_W     = $clog2(STARVE_LIMIT + 2);
   localparam logic [c_STV_W-1:0] c_STV_MAX  = c_STV_W'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]   c_CNT_MAX   = {CNT_W{1'b1}};

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   last_err_q, last_err_d;
   logic [c_CW_W-1:0]   word_q, word_d;
   logic [c_CW_W-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
   logic [c_STV_W-1:0]  starve_q, starve_d;

   logic                w_host_gnt;
   logic                w_scrub_gnt;
   logic                w_rd_en;
   logic                w_wr_en;
   logic [c_SYN_W-1:0]  w_syn;
   logic [c_CW_W-1:0]   w_fixed;
   logic                w_err;

   hamming_7_4_syndrome_fix u_fix (
      .cw_i    (word_q),
      .syn_o   (w_syn),
      .fixed_o (w_fixed),
      .err_o   (w_err)
   );

   // Port arbitration: host wins in RD/WR until it has held the port STARVE_LIMIT cycles in a row
   always_comb begin
      w_host_gnt  = host_req;
      w_scrub_gnt = 1'b0;
      starve_d    = starve_q;
      if (state_q == ST_WAIT) begin
         // read data is in flight on the shared port
         w_host_gnt = 1'b0;
      end else if ((state_q == ST_RD) || (state_q == ST_WR)) begin
         if (host_req && (starve_q < c_STV_MAX)) begin
            w_host_gnt = 1'b1;
            starve_d   = starve_q + 1'b1;
         end else begin
            w_host_gnt  = 1'b0;
            w_scrub_gnt = 1'b1;
            starve_d    = '0;
         end
      end
   end

   // Scrub sequencing: next state, datapath updates and RAM strobes
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_d     = word_q;
      wdata_d    = wdata_q;
      err_cnt_d  = err_cnt_q;
      last_err_d = last_err_q;
      w_rd_en    = 1'b0;
      w_wr_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_RD;
               addr_d     = '0;
               err_cnt_d  = '0;
               last_err_d = '0;
            end
         end
         ST_RD: begin
            if (w_scrub_gnt) begin
               w_rd_en = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            word_d  = mem_rdata;
            state_d = ST_CHK;
         end
         ST_CHK: begin
            // decoder raises err exactly when the syndrome is nonzero
            if (w_err && (w_syn != '0)) begin
               wdata_d    = w_fixed;
               last_err_d = addr_q;
               if (err_cnt_q != c_CNT_MAX) begin
                  err_cnt_d = err_cnt_q + 1'b1;
               end
               state_d = ST_WR;
            end else begin
               state_d = ST_NEXT;
            end
         end
         ST_WR: begin
            if (w_scrub_gnt) begin
               w_wr_en = 1'b1;
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (addr_q == c_LAST_ADDR) begin
               state_d = ST_DONE;
            end else begin
               addr_d  = addr_q + 1'b1;
               state_d = ST_RD;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         word_q     <= '0;
         wdata_q    <= '0;
         err_cnt_q  <= '0;
         last_err_q <= '0;
         starve_q   <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         word_q     <= word_d;
         wdata_q    <= wdata_d;
         err_cnt_q  <= err_cnt_d;
         last_err_q <= last_err_d;
         starve_q   <= starve_d;
      end
   end

   // Strobes are suppressed while reset is held so an aborted pass never touches the RAM
   assign mem_rd_en     = w_rd_en & ~rst;
   assign mem_wr_en     = w_wr_en & ~rst;
   assign host_gnt      = w_host_gnt;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done          = (state_q == ST_DONE);
   assign err_count     = err_cnt_q;
   assign last_err_addr = last_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hamming_7_4_scrub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hamming_7_4_scrub_ctrl
//  Purpose  : Randomised scoreboard bench for the Hamming (7,4) scrubber.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_7_4_scrub_ctrl;

   localparam int ADDR_W       = 4;
   localparam int DEPTH        = 12;
   localparam int STARVE_LIMIT = 8;
   localparam int CNT_W        = 3;
   localparam int RAM_N        = 1 << ADDR_W;
   localparam int CNT_SAT      = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              host_req = 1'b0;
   logic              busy, done, host_gnt, mem_rd_en, mem_wr_en;
   logic [ADDR_W-1:0] mem_addr, last_err_addr;
   logic [6:0]        mem_rdata, mem_wdata;
   logic [CNT_W-1:0]  err_count;

   always #5 clk = ~clk;

   hamming_7_4_scrub_ctrl #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .host_req(host_req), .host_gnt(host_gnt), .mem_addr(mem_addr),
      .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en),
      .mem_wdata(mem_wdata), .err_count(err_count), .last_err_addr(last_err_addr)
   );

   // ---------------- RAM model (1-cycle read latency) ----------------
   logic [6:0] mem [0:RAM_N-1];
   logic [6:0] img [0:RAM_N-1];
   logic [6:0] golden [0:RAM_N-1];
   logic       load = 1'b0;

   always @(posedge clk) begin
      if (load) begin
         for (int a = 0; a < RAM_N; a++) mem[a] <= img[a];
      end else begin
         if (mem_rd_en) mem_rdata <= mem[mem_addr];
         if (mem_wr_en) mem[mem_addr] <= mem_wdata;
      end
   end

   // ---------------- host traffic ----------------
   int host_pct = 0;
   always @(posedge clk) begin
      #1;
      host_req = ($urandom_range(0, 99) < host_pct);
   end

   // ---------------- scoreboard ----------------
   typedef struct { int kind; int addr; int data; } ev_t;  // kind 1=read 2=write 3=done
   ev_t sb[$];
   int  n_chk  = 0;
   int  n_pass = 0;
   logic prev_rd = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic sb_match(input string nm, input int kind, input int addr, input int data);
      ev_t e;
      e = '{0, 0, 0};
      if (sb.size() > 0) e = sb.pop_front();
      chk(nm, {8'(kind), 8'(addr), 8'(data)}, {8'(e.kind), 8'(e.addr), 8'(e.data)});
   endtask

   // Monitor: pops the expected transaction whenever the DUT drives one
   always @(negedge clk) begin
      if (rst) begin
         if (mem_wr_en) chk("rst_wr_en", mem_wr_en, 0);
         if (mem_rd_en) chk("rst_rd_en", mem_rd_en, 0);
         prev_rd = 1'b0;
      end else begin
         if (mem_rd_en || mem_wr_en) begin
            chk("single_strobe", mem_rd_en & mem_wr_en, 0);
            chk("gnt_with_strobe", host_gnt, 0);
         end
         if (prev_rd) chk("wait_host_gnt", host_gnt, 0);
         if (!busy) chk("idle_host_gnt", host_gnt, host_req);
         if (mem_rd_en) sb_match("read", 1, int'(mem_addr), 0);
         if (mem_wr_en) sb_match("write", 2, int'(mem_addr), int'(mem_wdata));
         if (done) begin
            sb_match("done_log", 3, int'(last_err_addr), int'(err_count));
            chk("busy_at_done", busy, 0);
         end
         prev_rd = mem_rd_en;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [6:0] encode(input logic [3:0] d);
      logic p2, p1, p0;
      p2 = d[3] ^ d[2] ^ d[1];
      p1 = d[3] ^ d[2] ^ d[0];
      p0 = d[3] ^ d[1] ^ d[0];
      return {d, p2, p1, p0};
   endfunction

   task automatic load_img();
      @(posedge clk); #1 load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
   endtask

   task automatic fill_mem(input int err_pct);
      for (int a = 0; a < RAM_N; a++) begin
         golden[a] = encode(4'($urandom_range(0, 15)));
         img[a]    = golden[a];
         if ($urandom_range(0, 99) < err_pct)
            img[a] = img[a] ^ 7'(1 << $urandom_range(0, 6));
      end
      load_img();
   endtask

   // Expected pass: every address read in order; each corrupted word rewritten with its clean value
   task automatic build_expect(output int lat);
      int n_err, last;
      n_err = 0; last = 0; lat = 0;
      sb.delete();
      for (int a = 0; a < DEPTH; a++) begin
         sb.push_back('{1, a, 0});
         lat += 4;
         if (img[a] != golden[a]) begin
            sb.push_back('{2, a, int'(golden[a])});
            n_err++; last = a; lat += 1;
         end
      end
      sb.push_back('{3, last, (n_err > CNT_SAT) ? CNT_SAT : n_err});
   endtask

   task automatic check_reset_vals();
      chk("rv_busy", busy, 0);
      chk("rv_done", done, 0);
      chk("rv_rd_en", mem_rd_en, 0);
      chk("rv_wr_en", mem_wr_en, 0);
      chk("rv_wdata", mem_wdata, 0);
      chk("rv_err_count", err_count, 0);
      chk("rv_last_err", last_err_addr, 0);
      chk("rv_addr", mem_addr, 0);
   endtask

   task automatic run_pass(input bit fill, input int err_pct, input int hp,
                           input bit repulse, input bit check_starve);
      int lat, n, pulse_at, gnt_cnt, rd_cycle;
      bit seen_rd, timed_out;
      if (fill) fill_mem(err_pct);
      build_expect(lat);
      host_pct = hp;
      pulse_at = $urandom_range(2, 20);
      gnt_cnt = 0; rd_cycle = 0; seen_rd = 0; timed_out = 0; n = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      forever begin
         @(negedge clk);
         n++;
         if (check_starve && !seen_rd) begin
            if (mem_rd_en) begin seen_rd = 1; rd_cycle = n; end
            else if (host_gnt) gnt_cnt++;
         end
         if (done) break;
         if (n > 4000) begin timed_out = 1; break; end
         start = repulse && (n == pulse_at);
      end
      start = 1'b0;
      if (timed_out) begin
         n_chk++;
         $display("FAIL pass_timeout: no done after %0d cycles", n);
      end
      if (hp == 0) chk("pass_latency", n, lat + 1);
      if (check_starve) begin
         chk("starve_host_cycles", gnt_cnt, STARVE_LIMIT);
         chk("starve_read_cycle", rd_cycle, STARVE_LIMIT + 1);
      end
      // start presented during the DONE cycle must not launch a pass
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("no_restart_after_done", busy, 0);
      end
      chk("sb_drained", sb.size(), 0);
   endtask

   task automatic reset_in_wr_test();
      int n;
      for (int a = 0; a < RAM_N; a++) begin
         golden[a] = encode(4'($urandom_range(0, 15)));
         img[a]    = golden[a];
      end
      img[0] = golden[0] ^ 7'h01;       // parity-bit error at address 0
      load_img();
      build_expect(n);
      host_pct = 100;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_rd_en && n < 50);
      chk("rt_first_read_cycle", n, STARVE_LIMIT + 1);
      // WAIT, CHK, then STARVE_LIMIT host cycles in WR; the next WR cycle would write
      repeat (STARVE_LIMIT + 2) @(posedge clk);
      @(negedge clk);
      chk("rt_host_owns_wr", host_gnt, 1);
      @(posedge clk); #1 rst = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("rt_no_write_in_reset", mem_wr_en, 0);
      @(posedge clk); #1 rst = 1'b0;
      host_pct = 0;
      @(negedge clk);
      check_reset_vals();
      // memory untouched by the aborted pass, so the rescan must repair address 0
      run_pass(1'b0, 0, 0, 1'b0, 1'b0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_vals();

      run_pass(1'b1, 0, 0, 1'b0, 1'b0);      // all clean, no host
      run_pass(1'b1, 30, 0, 1'b0, 1'b0);     // some corrections, no host
      run_pass(1'b1, 0, 100, 1'b0, 1'b1);    // host hogging the port
      for (int i = 0; i < 6; i++)
         run_pass(1'b1, $urandom_range(0, 60), $urandom_range(0, 90), 1'b1, 1'b0);
      run_pass(1'b1, 100, 20, 1'b1, 1'b0);   // every word bad: counter saturates
      reset_in_wr_test();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
